signed_acc_stage: RTL

- Registered accumulate stage that consumes a stream of signed operands and keeps a running W-bit two's-complement accumulator.
- After each accepted operation it presents the result together with zero/negative/overflow/carry flags.
- Sits directly downstream of the operand source and upstream of the flag/branch logic.
- Single-entry output register with valid/ready handshake on both sides.

---
 rtl/acc_pkg.sv | 29 ++
 rtl/signed_acc_stage_if.sv | 34 +++
 rtl/signed_addsub_core.sv | 33 +++
 rtl/signed_acc_stage.sv | 105 ++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared op-codes, default widths and the result-flag bundle for the signed accumulate stage.
package acc_pkg;

  localparam int unsigned DEFAULT_W     = 5;
  localparam int unsigned DEFAULT_CNT_W = 8;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
    logic carry;
  } acc_flags_t;

  function automatic acc_flags_t make_flags(input logic zero, input logic neg,
                                            input logic ovf, input logic carry);
    acc_flags_t f;
    f.zero  = zero;
    f.neg   = neg;
    f.ovf   = ovf;
    f.carry = carry;
    return f;
  endfunction

endpackage

// File: rtl/signed_acc_stage_if.sv
// Operand-in / result-out handshake bundle of the signed accumulate stage.
interface signed_acc_stage_if #(
    parameter int unsigned W     = acc_pkg::DEFAULT_W,
    parameter int unsigned CNT_W = acc_pkg::DEFAULT_CNT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     operand;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     acc;
    logic             zero_flag;
    logic             neg_flag;
    logic             overflow_flag;
    logic             carry_flag;
    logic             sticky_ovf;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, op, operand, carry_in, out_ready,
        input  in_ready, out_valid, acc, zero_flag, neg_flag, overflow_flag, carry_flag,
        input  sticky_ovf, op_count
    );

    modport slave (
        input  in_valid, op, operand, carry_in, out_ready,
        output in_ready, out_valid, acc, zero_flag, neg_flag, overflow_flag, carry_flag,
        output sticky_ovf, op_count
    );

endinterface

// File: rtl/signed_addsub_core.sv
// Combinational W-bit ripple adder/subtractor with carry-out and signed-overflow detection.
module signed_addsub_core #(
    parameter int unsigned W = acc_pkg::DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] r,
    output logic         c,
    output logic         ovf
);

    logic [W-1:0] b_eff;
    logic         carry;
    logic         carry_msb;

    always_comb begin
        // Subtraction is a + ~b + 1; the external carry only matters for ADD.
        b_eff     = sub ? ~b : b;
        carry     = sub ? 1'b1 : cin;
        carry_msb = 1'b0;
        r         = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i == W - 1) carry_msb = carry;
            r[i]  = a[i] ^ b_eff[i] ^ carry;
            carry = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        c   = carry;
        ovf = carry_msb ^ carry;
    end

endmodule

// File: rtl/signed_acc_stage.sv
// Registered signed accumulate stage: single-entry result register with valid/ready on both sides.
module signed_acc_stage
    import acc_pkg::*;
#(
    parameter int unsigned W     = DEFAULT_W,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input logic                clk,
    input logic                rst_n,
    signed_acc_stage_if.slave  bus
);

    localparam logic StEmpty = 1'b0;
    localparam logic StFull  = 1'b1;

    logic             state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    acc_flags_t       flags_q, flags_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic             accept;
    logic             in_ready;
    logic [W-1:0]     sum_r;
    logic             sum_c;
    logic             sum_ovf;

    signed_addsub_core #(
        .W (W)
    ) u_core (
        .a   (acc_q),
        .b   (bus.operand),
        .sub (bus.op == OP_SUB),
        .cin (bus.carry_in),
        .r   (sum_r),
        .c   (sum_c),
        .ovf (sum_ovf)
    );

    // Pass-through ready: a held result frees its slot in the same cycle it drains.
    assign in_ready = rst_n && ((state_q == StEmpty) || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (accept) begin
            state_d = StFull;
            case (bus.op)
                OP_ADD, OP_SUB: begin
                    acc_d    = sum_r;
                    flags_d  = make_flags(sum_r == '0, sum_r[W-1], sum_ovf, sum_c);
                    sticky_d = sticky_q | sum_ovf;
                    cnt_d    = cnt_inc;
                end
                OP_LOAD: begin
                    acc_d   = bus.operand;
                    flags_d = make_flags(bus.operand == '0, bus.operand[W-1], 1'b0, 1'b0);
                    cnt_d   = cnt_inc;
                end
                OP_CLEAR: begin
                    acc_d    = '0;
                    flags_d  = make_flags(1'b1, 1'b0, 1'b0, 1'b0);
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                end
                default: ;
            endcase
        end else if ((state_q == StFull) && bus.out_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            acc_q    <= '0;
            flags_q  <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = (state_q == StFull);
    assign bus.acc           = acc_q;
    assign bus.zero_flag     = flags_q.zero;
    assign bus.neg_flag      = flags_q.neg;
    assign bus.overflow_flag = flags_q.ovf;
    assign bus.carry_flag    = flags_q.carry;
    assign bus.sticky_ovf    = sticky_q;
    assign bus.op_count      = cnt_q;

endmodule
